// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the multi-channel PWM generator.
package pwm_pkg;

   localparam int CNT_W_DEF  = 11;
   localparam int PRE_W_DEF  = 8;
   localparam int NUM_CH_MAX = 16;

   typedef logic [CNT_W_DEF-1:0] duty_t;

   // Width of a channel index; never narrower than one bit.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty register and registered compare.
// The pending duty always accepts writes; the active duty is only replaced
// when the top asserts load (period boundary, or while disabled). A write
// that lands on a load cycle is forwarded straight into the active duty.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             load,
   input  logic             wr_hit,
   input  logic [CNT_W-1:0] wr_duty,
   input  logic [CNT_W-1:0] cnt,
   output logic             pwm
);

   logic [CNT_W-1:0] duty_pend;
   logic [CNT_W-1:0] duty_act;
   logic [CNT_W-1:0] duty_next;

   // Newest pending value, including a write arriving this cycle (bypass path).
   assign duty_next = wr_hit ? wr_duty : duty_pend;

   // Duty registers and the compare; output lags the counter by one clk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         duty_pend <= '0;
         duty_act  <= '0;
         pwm       <= 1'b0;
      end else begin
         duty_pend <= duty_next;
         if (load) begin
            duty_act <= duty_next;
         end
         pwm <= run && (cnt < duty_act);
      end
   end

endmodule

// File: rtl/pwm_multi_gen.sv
// NUM_CH-channel PWM generator sharing one prescaler and one period counter.
// Period and duty changes take effect only at a period boundary. The first
// enabled clk after a disabled one is itself a boundary: it loads the active
// values, pulses period_start on the following clk and leaves the counter at
// 0, so every period, including the first, starts from cnt=0.
module pwm_multi_gen
   import pwm_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int PRE_W  = PRE_W_DEF,
   parameter int CH_W   = ch_width(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [PRE_W-1:0]  prescale,
   input  logic [CNT_W-1:0]  period,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [CNT_W-1:0]  wr_duty,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              period_start
);

   logic             en_q;
   logic [PRE_W-1:0] pre_cnt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] period_act;
   logic             run;
   logic             start;
   logic             tick;
   logic             wrap;
   logic             boundary;
   logic             load;

   // run: enabled now and on the previous clk, so the counter is live.
   assign run      = enable && en_q;
   assign start    = enable && !en_q;
   assign tick     = run && (pre_cnt == prescale);
   assign wrap     = tick && (cnt == period_act);
   assign boundary = start || wrap;
   // While disabled the active registers track the pending ones every clk.
   assign load     = boundary || !enable;

   // Remember last clk's enable to detect the rising edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_q <= 1'b0;
      end else begin
         en_q <= enable;
      end
   end

   // Prescaler: counts 0..prescale; a lowered prescale wraps via overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_cnt <= '0;
      end else if (!run || tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   // Period counter: advances on tick, wraps to 0 after period_act.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (!run || wrap) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Active period register and the boundary marker pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         period_act   <= '0;
         period_start <= 1'b0;
      end else begin
         if (load) begin
            period_act <= period;
         end
         period_start <= boundary;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic wr_hit;
      // Out-of-range channel indices match no channel and are dropped.
      assign wr_hit = wr_en && (wr_ch == CH_W'(i));

      pwm_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .run     (run),
         .load    (load),
         .wr_hit  (wr_hit),
         .wr_duty (wr_duty),
         .cnt     (cnt),
         .pwm     (pwm_out[i])
      );
   end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Bench for pwm_multi_gen: table of configurations checked by period length
// and high-time per channel, directed corner sequences, then random traffic.
// A cycle model built from the behavioural rules checks every clk.
module tb_pwm_multi_gen;
   import pwm_pkg::*;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = CNT_W_DEF;
   localparam int PRE_W  = PRE_W_DEF;
   localparam int CH_W   = 2;
   localparam int BUDGET = 5000;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              enable = 1'b0;
   logic [PRE_W-1:0]  prescale = '0;
   logic [CNT_W-1:0]  period = '0;
   logic              wr_en = 1'b0;
   logic [CH_W-1:0]   wr_ch = '0;
   logic [CNT_W-1:0]  wr_duty = '0;
   logic [NUM_CH-1:0] pwm_out;
   logic              period_start;

   int checks = 0;
   int errors = 0;

   pwm_multi_gen #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W),
      .PRE_W  (PRE_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .prescale     (prescale),
      .period       (period),
      .wr_en        (wr_en),
      .wr_ch        (wr_ch),
      .wr_duty      (wr_duty),
      .pwm_out      (pwm_out),
      .period_start (period_start)
   );

   // clock
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int            m_pre, m_cnt, m_per;
   int            m_pend [NUM_CH];
   int            m_act  [NUM_CH];
   bit            m_on;
   logic [NUM_CH-1:0] m_out;
   logic          m_ps;

   task automatic model_reset();
      m_pre = 0; m_cnt = 0; m_per = 0; m_on = 0; m_out = '0; m_ps = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         m_pend[i] = 0;
         m_act[i]  = 0;
      end
   endtask

   task automatic model_load();
      m_per = int'(period);
      for (int i = 0; i < NUM_CH; i++) m_act[i] = m_pend[i];
   endtask

   task automatic model_step();
      logic [NUM_CH-1:0] o;
      bit tick, wrap;
      o = '0;
      if (enable && m_on)
         for (int i = 0; i < NUM_CH; i++) o[i] = (m_cnt < m_act[i]);
      if (wr_en && int'(wr_ch) < NUM_CH) m_pend[wr_ch] = int'(wr_duty);
      if (!enable) begin
         m_on = 0; m_cnt = 0; m_pre = 0; m_ps = 0;
         model_load();
      end else if (!m_on) begin
         m_on = 1; m_ps = 1;
         model_load();
      end else begin
         tick  = (m_pre == int'(prescale));
         m_pre = tick ? 0 : (m_pre + 1) % (1 << PRE_W);
         wrap  = tick && (m_cnt == m_per);
         m_ps  = wrap;
         if (wrap) begin
            m_cnt = 0;
            model_load();
         end else if (tick) begin
            m_cnt = m_cnt + 1;
         end
      end
      m_out = o;
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
      end
   endtask

   // One clk: edge, model update, compare, return at the falling edge.
   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check("cyc_pwm_out", int'(pwm_out), int'(m_out));
      check("cyc_period_start", int'(period_start), int'(m_ps));
      @(negedge clk);
   endtask

   task automatic sync_start();
      int n;
      n = 0;
      while (period_start !== 1'b1 && n < BUDGET) begin
         cyc();
         n++;
      end
      if (n >= BUDGET) check("sync_timeout", 1, 0);
   endtask

   // Window measurement from one period_start to the next, with an optional
   // input action at a given offset (1 = duty write, 2 = period change).
   int w_len;
   int w_hi [NUM_CH];
   int act_off = -1;
   int act_kind = 0;
   int act_ch = 0;
   int act_val = 0;

   task automatic measure_window();
      w_len = 0;
      for (int i = 0; i < NUM_CH; i++) w_hi[i] = 0;
      do begin
         for (int i = 0; i < NUM_CH; i++) w_hi[i] += int'(pwm_out[i]);
         if (w_len == act_off) begin
            if (act_kind == 1) begin
               wr_en = 1'b1; wr_ch = CH_W'(act_ch); wr_duty = CNT_W'(act_val);
            end else if (act_kind == 2) begin
               period = CNT_W'(act_val);
            end
         end
         w_len++;
         cyc();
         wr_en = 1'b0;
      end while (period_start !== 1'b1 && w_len < BUDGET);
      if (w_len >= BUDGET) check("window_timeout", 1, 0);
      act_off = -1;
      act_kind = 0;
   endtask

   task automatic write_duty(input int ch, input int d);
      wr_en = 1'b1; wr_ch = CH_W'(ch); wr_duty = CNT_W'(d);
      cyc();
      wr_en = 1'b0;
   endtask

   // Disable, program everything, enable, and settle past the first period.
   task automatic apply_cfg(input int pre, input int per,
                            input int d0, input int d1, input int d2, input int d3);
      enable = 1'b0;
      cyc();
      prescale = PRE_W'(pre);
      period   = CNT_W'(per);
      write_duty(0, d0);
      write_duty(1, d1);
      write_duty(2, d2);
      write_duty(3, d3);
      enable = 1'b1;
      sync_start();
      measure_window();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int pre;
      int per;
      logic [NUM_CH-1:0][15:0] d;
      int len;
      logic [NUM_CH-1:0][15:0] hi;
   } vec_t;

   vec_t vecs [4];

   task automatic set_vec(input int k, input int pre, input int per,
                          input int d0, input int d1, input int d2, input int d3,
                          input int len,
                          input int h0, input int h1, input int h2, input int h3);
      vecs[k].pre = pre;
      vecs[k].per = per;
      vecs[k].d[0] = 16'(d0); vecs[k].d[1] = 16'(d1);
      vecs[k].d[2] = 16'(d2); vecs[k].d[3] = 16'(d3);
      vecs[k].len = len;
      vecs[k].hi[0] = 16'(h0); vecs[k].hi[1] = 16'(h1);
      vecs[k].hi[2] = 16'(h2); vecs[k].hi[3] = 16'(h3);
   endtask

   duty_t big_duty;

   initial begin
      // Period length (P+1)*(pre+1); high time min(D,P+1)*(pre+1).
      big_duty = '1;
      set_vec(0, 0,  9,  3,  0, 10, 5,            10,  3,  0, 10,  5);
      set_vec(1, 2,  3,  2,  2,  4, 0,            12,  6,  6, 12,  0);
      set_vec(2, 1,  0,  0,  1,  2, int'(big_duty), 2, 0,  2,  2,  2);
      set_vec(3, 3, 20, 21, 20,  1, 7,            84, 84, 80,  4, 28);

      // reset
      model_reset();
      #1 rst = 1'b0;
      #2;
      check("rst_pwm_out", int'(pwm_out), 0);
      check("rst_period_start", int'(period_start), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      cyc();

      // table-driven configurations
      for (int k = 0; k < 4; k++) begin
         apply_cfg(vecs[k].pre, vecs[k].per, int'(vecs[k].d[0]), int'(vecs[k].d[1]),
                   int'(vecs[k].d[2]), int'(vecs[k].d[3]));
         measure_window();
         check($sformatf("vec%0d_len", k), w_len, vecs[k].len);
         for (int i = 0; i < NUM_CH; i++)
            check($sformatf("vec%0d_hi%0d", k, i), w_hi[i], int'(vecs[k].hi[i]));
      end

      // shadowing: ch0 write at cnt=4 only shows in the next period
      apply_cfg(0, 9, 3, 0, 10, 5);
      act_off = 4; act_kind = 1; act_ch = 0; act_val = 7;
      measure_window();
      check("shadow_cur_hi0", w_hi[0], 3);
      // write on the boundary cycle itself reaches the very next period
      act_off = 9; act_kind = 1; act_ch = 1; act_val = 2;
      measure_window();
      check("shadow_next_hi0", w_hi[0], 7);
      check("bwr_cur_hi1", w_hi[1], 0);
      measure_window();
      check("bwr_next_hi1", w_hi[1], 2);
      check("bwr_next_len", w_len, 10);

      // prescaler with a mid-period period change
      apply_cfg(2, 3, 2, 2, 2, 2);
      act_off = 5; act_kind = 2; act_val = 7;
      measure_window();
      check("perchg_cur_len", w_len, 12);
      check("perchg_cur_hi0", w_hi[0], 6);
      measure_window();
      check("perchg_next_len", w_len, 24);
      check("perchg_next_hi0", w_hi[0], 6);

      // enable toggle at cnt=5 with a pending write while disabled
      apply_cfg(0, 9, 3, 0, 10, 5);
      repeat (5) cyc();
      enable = 1'b0;
      wr_en = 1'b1; wr_ch = 2'd3; wr_duty = 11'd8;
      cyc();
      wr_en = 1'b0;
      check("dis_pwm_out", int'(pwm_out), 0);
      check("dis_period_start", int'(period_start), 0);
      repeat (2) cyc();
      enable = 1'b1;
      cyc();
      check("reen_period_start", int'(period_start), 1);
      check("reen_pwm_out", int'(pwm_out), 0);
      measure_window();
      check("reen_hi3", w_hi[3], 8);
      check("reen_hi0", w_hi[0], 3);
      check("reen_len", w_len, 10);

      // asynchronous reset between edges while ch2 is high
      repeat (3) cyc();
      #2 rst = 1'b0;
      #1;
      check("arst_pwm_out", int'(pwm_out), 0);
      check("arst_period_start", int'(period_start), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      cyc();

      // random traffic against the cycle model
      prescale = '0;
      period = 11'd5;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 39) == 0) enable = ~enable;
         if ($urandom_range(0, 59) == 0) prescale = PRE_W'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0) period = CNT_W'($urandom_range(0, 12));
         if ($urandom_range(0, 3) == 0) begin
            wr_en = 1'b1;
            wr_ch = CH_W'($urandom_range(0, NUM_CH - 1));
            wr_duty = CNT_W'($urandom_range(0, 14));
         end
         cyc();
         wr_en = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
